// File: rtl/spi_master_ctrl_pkg.sv
// Shared types and constants for the SPI master controller and its shifter.
// MEM_WIDTH and the slave-select levels match the SPI slave + RAM datapath.
package spi_master_ctrl_pkg;

    localparam int   MEM_WIDTH          = 8;
    localparam logic SLAVE_SELECTED     = 1'b0;
    localparam logic SLAVE_NOT_SELECTED = 1'b1;
    localparam int   CNT_W              = 4;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEL     = 3'd1,
        CMD     = 3'd2,
        SHIFT   = 3'd3,
        RD_WAIT = 3'd4,
        RD_CAP  = 3'd5,
        GAP     = 3'd6
    } master_state_e;

endpackage

// File: rtl/spi_master_ctrl_sva.sv
// Protocol properties for spi_master_ctrl, attached to every instance by bind
// so the controller source stays free of checker code.
module spi_master_ctrl_sva
    import spi_master_ctrl_pkg::*;
#(
    parameter int MEM_WIDTH = spi_master_ctrl_pkg::MEM_WIDTH
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic                 req_valid,
    input logic                 req_ready,
    input logic [1:0]           req_op,
    input logic [MEM_WIDTH-1:0] req_data,
    input logic                 rsp_valid,
    input logic [MEM_WIDTH-1:0] rsp_data,
    input logic                 busy,
    input logic                 SS_n,
    input logic                 MOSI,
    input logic                 MISO,
    input master_state_e        state
);

    // Request payload and MISO only matter through the frame contents.
    logic unused_inputs;
    assign unused_inputs = ^{req_op, req_data, MISO};

    a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
        req_ready == (state == IDLE));
    a_busy_ready: assert property (@(posedge clk) disable iff (!rst_n)
        busy == !req_ready);
    a_idle_deselect: assert property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE) |-> (SS_n == SLAVE_NOT_SELECTED));
    a_sel_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        (state == SEL) |-> (SS_n == SLAVE_SELECTED) && !MOSI);
    a_accept: assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid && req_ready) |=> (state == SEL));
    a_rsp_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |=> !rsp_valid);
    a_rsp_in_gap: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (state == GAP));
    a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        !rsp_valid |-> $stable(rsp_data));

endmodule

bind spi_master_ctrl spi_master_ctrl_sva #(
    .MEM_WIDTH (MEM_WIDTH)
) u_sva (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .state     (state)
);

// File: rtl/spi_master_shifter.sv
// Frame datapath: loadable PISO driving MOSI (MSB first) and a SIPO that
// collects the slave's MISO reply MSB first.
module spi_master_shifter
    import spi_master_ctrl_pkg::*;
#(
    parameter int WIDTH = MEM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH+1:0] load_data,
    input  logic             shift_en,
    input  logic             cap_en,
    input  logic             miso,
    output logic             mosi_bit,
    output logic [WIDTH-1:0] cap_next
);

    logic [WIDTH+1:0] piso_q;
    logic [WIDTH-1:0] sipo_q;

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design updates from pre-edge values, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            piso_q <= '0;
            sipo_q <= '0;
        end else begin
            if (load) begin
                piso_q <= load_data;
            end else if (shift_en) begin
                piso_q <= {piso_q[WIDTH:0], 1'b0};
            end
            if (cap_en) begin
                sipo_q <= cap_next;
            end
        end
    end

    assign mosi_bit = piso_q[WIDTH+1];
    // Exposed so the controller can register the final byte on the same edge
    // that samples its last bit.
    assign cap_next = {sipo_q[WIDTH-2:0], miso};

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: accepts one RAM operation per request, serialises it
// as an SS_n/MOSI frame and, for RD_DATA, returns the slave's MISO byte.
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int MEM_WIDTH  = spi_master_ctrl_pkg::MEM_WIDTH,
    parameter int READ_WAIT  = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [MEM_WIDTH-1:0] req_data,
    output logic                 rsp_valid,
    output logic [MEM_WIDTH-1:0] rsp_data,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(MEM_WIDTH + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] CAP_LOAD   = CNT_W'(MEM_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    master_state_e          state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   rd_frame_q;
    logic                   load, shift_en, cap_en;
    logic                   mosi_bit;
    logic [MEM_WIDTH-1:0]   cap_next;
    logic [MEM_WIDTH-1:0]   payload;
    logic                   is_rd_data;

    assign is_rd_data = (spi_op_e'(req_op) == RD_DATA);
    assign payload    = is_rd_data ? '0 : req_data;

    spi_master_shifter #(
        .WIDTH (MEM_WIDTH)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data ({req_op, payload}),
        .shift_en  (shift_en),
        .cap_en    (cap_en),
        .miso      (MISO),
        .mosi_bit  (mosi_bit),
        .cap_next  (cap_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_frame_q <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rsp_valid <= (state == RD_CAP) && (cnt == '0);
            if (load) begin
                rd_frame_q <= is_rd_data;
            end
            if ((state == RD_CAP) && (cnt == '0)) begin
                rsp_data <= cap_next;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        shift_en   = 1'b0;
        cap_en     = 1'b0;
        SS_n       = SLAVE_NOT_SELECTED;
        MOSI       = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    load       = 1'b1;
                    state_next = SEL;
                    cnt_next   = '0;
                end
            end
            SEL: begin
                SS_n       = SLAVE_SELECTED;
                state_next = CMD;
            end
            CMD: begin
                SS_n       = SLAVE_SELECTED;
                MOSI       = mosi_bit;
                state_next = SHIFT;
                cnt_next   = SHIFT_LOAD;
            end
            SHIFT: begin
                SS_n     = SLAVE_SELECTED;
                MOSI     = mosi_bit;
                shift_en = 1'b1;
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (rd_frame_q) begin
                    state_next = RD_WAIT;
                    cnt_next   = WAIT_LOAD;
                end else begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end
            end
            RD_WAIT: begin
                SS_n = SLAVE_SELECTED;
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    state_next = RD_CAP;
                    cnt_next   = CAP_LOAD;
                end
            end
            RD_CAP: begin
                SS_n   = SLAVE_SELECTED;
                cap_en = 1'b1;
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign req_ready = !busy;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed + randomized bench for spi_master_ctrl; frame timing and read data
// are predicted from a slave/RAM model kept at transaction level.
module tb_spi_master_ctrl;

    localparam int MW = 8;
    localparam int RW = 2;
    localparam int GC = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [MW-1:0] req_data;
    logic          rsp_valid;
    logic [MW-1:0] rsp_data;
    logic          busy;
    logic          SS_n;
    logic          MOSI;
    logic          MISO;

    spi_master_ctrl #(
        .MEM_WIDTH  (MW),
        .READ_WAIT  (RW),
        .GAP_CYCLES (GC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Transaction-level slave + RAM model.
    logic [MW-1:0] ram [256];
    logic [MW-1:0] wr_addr = '0;
    logic [MW-1:0] rd_addr = '0;
    logic [MW-1:0] exp_rsp = '0;
    logic [11:0]   last_mosi;
    int            last_lows;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slave_model(input logic [1:0] op, input logic [MW-1:0] d,
                               output logic [MW-1:0] rd);
        rd = ram[rd_addr];
        case (op)
            2'b00: wr_addr = d;
            2'b01: ram[wr_addr] = d;
            2'b10: rd_addr = d;
            default: ;
        endcase
    endtask

    // Presents one request at the current negedge, follows its frame cycle by
    // cycle and returns on the negedge where the controller is ready again.
    task automatic run_frame(input logic [1:0] op, input logic [MW-1:0] data,
                             input logic [MW-1:0] miso_byte, input bit keep_valid,
                             input logic [1:0] nop, input logic [MW-1:0] ndata);
        int       len, waited, lows;
        bit       rdy_bad, rsp_early;
        bit       is_rd;
        logic [11:0] mosi_exp, mosi_obs;
        is_rd = (op == 2'b11);
        len   = is_rd ? 12 + RW + MW : 12;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        waited = 0;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        mosi_exp  = {1'b0, op[1], op, (is_rd ? 8'h00 : data)};
        mosi_obs  = '0;
        lows      = 0;
        rdy_bad   = 0;
        rsp_early = 0;
        for (int k = 1; k <= len + GC + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (keep_valid) begin
                    req_op   = nop;
                    req_data = ndata;
                end else begin
                    req_valid = 1'b0;
                    req_op    = 2'($urandom);
                    req_data  = 8'($urandom);
                end
            end
            if (is_rd && k > len - MW && k <= len) MISO = miso_byte[len - k];
            else                                   MISO = 1'($urandom);
            if (k <= 12) mosi_obs[12 - k] = MOSI;
            if (k <= len) begin
                if (SS_n == 1'b0) lows++;
                if (req_ready || !busy) rdy_bad = 1;
                if (rsp_valid) rsp_early = 1;
            end
            if (k == len + 1) begin
                if (is_rd) exp_rsp = miso_byte;
                check("gap_ss_n", 32'(SS_n), 32'd1);
                check("gap_rsp_valid", 32'(rsp_valid), 32'(is_rd));
                check("gap_rsp_data", 32'(rsp_data), 32'(exp_rsp));
            end
            if (k == len + GC + 1) begin
                check("ready_after_gap", 32'(req_ready), 32'd1);
                check("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
                check("idle_ss_n", 32'(SS_n), 32'd1);
            end
        end
        check("ss_low_cycles", 32'(lows), 32'(len));
        check("mosi_bits", 32'(mosi_obs), 32'(mosi_exp));
        check("ready_low_in_frame", 32'(rdy_bad), 32'd0);
        check("no_early_rsp", 32'(rsp_early), 32'd0);
        last_mosi = mosi_obs;
        last_lows = lows;
    endtask

    initial begin
        logic [MW-1:0] rd, d0, d1, d2;
        logic [1:0]    op;
        for (int i = 0; i < 256; i++) ram[i] = '0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = '0;
        MISO      = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ss_n", 32'(SS_n), 32'd1);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // WR_ADDR 0x5A with the literal MOSI sequence.
        slave_model(2'b00, 8'h5A, rd);
        run_frame(2'b00, 8'h5A, rd, 0, 2'b00, '0);
        check("wr_addr_5a_mosi", 32'(last_mosi[10:0]), 32'(11'b000_0101_1010));
        check("wr_addr_5a_len", 32'(last_lows), 32'd12);

        // WR_DATA 0xC3, then read it back through RD_ADDR/RD_DATA.
        slave_model(2'b01, 8'hC3, rd);
        run_frame(2'b01, 8'hC3, rd, 0, 2'b00, '0);
        slave_model(2'b10, 8'h5A, rd);
        run_frame(2'b10, 8'h5A, rd, 0, 2'b00, '0);
        slave_model(2'b11, 8'h77, rd);
        check("ram_5a_model", 32'(rd), 32'hC3);
        run_frame(2'b11, 8'h77, rd, 0, 2'b00, '0);
        check("rd_data_c3", 32'(rsp_data), 32'hC3);
        check("rd_data_len", 32'(last_lows), 32'(12 + RW + MW));

        // MISO pattern 0xA5 without a slave, then a write leaves it held.
        run_frame(2'b11, 8'h00, 8'hA5, 0, 2'b00, '0);
        check("forced_a5", 32'(rsp_data), 32'hA5);
        run_frame(2'b00, 8'h3C, 8'h00, 0, 2'b00, '0);
        check("a5_held", 32'(rsp_data), 32'hA5);
        wr_addr = 8'h3C;

        // Back-to-back with req_valid held and payload changing mid-frame.
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        slave_model(2'b00, d0, rd);
        run_frame(2'b00, d0, rd, 1, 2'b01, d1);
        slave_model(2'b01, d1, rd);
        run_frame(2'b01, d1, rd, 1, 2'b10, d2);
        slave_model(2'b10, d2, rd);
        run_frame(2'b10, d2, rd, 0, 2'b00, '0);

        // Reset in the middle of SHIFT.
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_data  = 8'hFF;
        @(posedge clk);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ss_n", 32'(SS_n), 32'd1);
        check("midrst_mosi", 32'(MOSI), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_data", 32'(rsp_data), 32'd0);
        exp_rsp   = '0;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'({busy, SS_n, req_ready}), 32'b011);

        // Randomized traffic through the slave/RAM model.
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom);
            d0 = 8'($urandom_range(0, 7));
            if (op == 2'b01) d0 = 8'($urandom);
            slave_model(op, d0, rd);
            run_frame(op, d0, rd, 0, 2'b00, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
